// File: rtl/wb_stage_pkg.sv
// Shared core definitions for the write-back stage: datapath width,
// load funct3 encodings and the write-back FSM state type.
package wb_stage_pkg;

    localparam int XLEN = 64;

    // Load funct3 encodings as they arrive from the memory stage.
    localparam logic [2:0] LD_LB  = 3'd0;
    localparam logic [2:0] LD_LH  = 3'd1;
    localparam logic [2:0] LD_LW  = 3'd2;
    localparam logic [2:0] LD_LD  = 3'd3;
    localparam logic [2:0] LD_LBU = 3'd4;
    localparam logic [2:0] LD_LHU = 3'd5;
    localparam logic [2:0] LD_LWU = 3'd6;

    // IDLE: ready for an instruction. WAIT_RESP: a load is waiting for data.
    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_RESP = 1'b1
    } wb_state_t;

endpackage

// File: rtl/wb_stage_load_align.sv
// load_align: purely combinational lane select and sign/zero extension
// of a doubleword-aligned load response. Misaligned offsets are forced to
// the natural alignment of the access size. funct3 7 behaves as ld.
module load_align
    import wb_stage_pkg::*;
#(
    parameter int W = XLEN
) (
    input  logic [2:0]   i_func,
    input  logic [2:0]   i_addr_lo,
    input  logic [W-1:0] i_rdata,
    output logic [W-1:0] o_data
);

    logic [2:0]   w_off;
    logic [W-1:0] w_lane;

    // Clear the low log2(size) offset bits; size comes from funct3[1:0].
    always_comb begin
        w_off = 3'd0;
        case (i_func[1:0])
            2'd0:    w_off = i_addr_lo;
            2'd1:    w_off = {i_addr_lo[2:1], 1'b0};
            2'd2:    w_off = {i_addr_lo[2], 2'b00};
            default: w_off = 3'd0;
        endcase
    end

    // Move the selected lane down to bit 0.
    assign w_lane = i_rdata >> {w_off, 3'b000};

    // Sign- or zero-extend the lane according to the load type.
    always_comb begin
        o_data = w_lane;
        case (i_func)
            LD_LB:   o_data = {{(W-8){w_lane[7]}},   w_lane[7:0]};
            LD_LH:   o_data = {{(W-16){w_lane[15]}}, w_lane[15:0]};
            LD_LW:   o_data = {{(W-32){w_lane[31]}}, w_lane[31:0]};
            LD_LBU:  o_data = {{(W-8){1'b0}},        w_lane[7:0]};
            LD_LHU:  o_data = {{(W-16){1'b0}},       w_lane[15:0]};
            LD_LWU:  o_data = {{(W-32){1'b0}},       w_lane[31:0]};
            default: o_data = w_lane;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// wb_stage: write-back stage of the in-order core. Accepts retiring
// instructions over in_valid/in_ready, waits for the data-memory response
// on loads, and drives the register file write port from one registered
// output stage.
// Optional feature macro: WB_DIFFTEST_COMMIT_EN adds commit_valid,
// commit_pc, commit_inst and commit_cnt outputs.
//
// Handshake: an instruction transfers on a rising edge where
// in_valid & in_ready are both 1; in_ready is 1 exactly when the FSM is
// IDLE and does not depend on in_valid. dmem_rvalid is a one-cycle
// response strobe with no back-pressure, only honoured in WAIT_RESP.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int XLEN = wb_stage_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [63:0]     in_pc,
    input  logic [31:0]     in_inst,
    input  logic [4:0]      in_rd,
    input  logic            in_rd_wen,
    input  logic            in_is_load,
    input  logic [2:0]      in_load_func,
    input  logic [2:0]      in_addr_lo,
    input  logic [XLEN-1:0] in_result,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
`ifdef WB_DIFFTEST_COMMIT_EN
    output logic            commit_valid,
    output logic [63:0]     commit_pc,
    output logic [31:0]     commit_inst,
    output logic [63:0]     commit_cnt,
`endif
    output wb_state_t       dbg_state
);

    wb_state_t       r_state;
    wb_state_t       w_state_next;
    logic            w_accept;

    // Latched load context while the response is outstanding.
    logic [4:0]      r_ld_rd;
    logic            r_ld_wen;
    logic [2:0]      r_ld_func;
    logic [2:0]      r_ld_addr_lo;

    // Retirement selected this cycle, fed into the output register.
    logic            w_retire;
    logic            w_ret_wen;
    logic [4:0]      w_ret_rd;
    logic [XLEN-1:0] w_ret_data;
    logic [XLEN-1:0] w_align_data;

    logic            r_rf_we;
    logic [4:0]      r_rf_waddr;
    logic [XLEN-1:0] r_rf_wdata;

`ifdef WB_DIFFTEST_COMMIT_EN
    logic [63:0]     r_ld_pc;
    logic [31:0]     r_ld_inst;
    logic [63:0]     w_ret_pc;
    logic [31:0]     w_ret_inst;
    logic            r_commit_valid;
    logic [63:0]     r_commit_pc;
    logic [31:0]     r_commit_inst;
    logic [63:0]     r_commit_cnt;
`else
    // PC and instruction word only feed the commit trace.
    logic            w_unused_commit;
    assign w_unused_commit = ^{in_pc, in_inst};
`endif

    assign in_ready  = (r_state == IDLE);
    assign w_accept  = in_valid & in_ready;
    assign dbg_state = r_state;

    load_align #(
        .W(XLEN)
    ) u_load_align (
        .i_func    (r_ld_func),
        .i_addr_lo (r_ld_addr_lo),
        .i_rdata   (dmem_rdata),
        .o_data    (w_align_data)
    );

    // Next-state and retirement select: non-loads retire on acceptance,
    // loads retire when their response arrives.
    always_comb begin
        w_state_next = r_state;
        w_retire     = 1'b0;
        w_ret_wen    = 1'b0;
        w_ret_rd     = 5'd0;
        w_ret_data   = '0;
`ifdef WB_DIFFTEST_COMMIT_EN
        w_ret_pc     = 64'd0;
        w_ret_inst   = 32'd0;
`endif
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (in_is_load) begin
                        w_state_next = WAIT_RESP;
                    end else begin
                        w_retire   = 1'b1;
                        w_ret_wen  = in_rd_wen;
                        w_ret_rd   = in_rd;
                        w_ret_data = in_result;
`ifdef WB_DIFFTEST_COMMIT_EN
                        w_ret_pc   = in_pc;
                        w_ret_inst = in_inst;
`endif
                    end
                end
            end
            WAIT_RESP: begin
                if (dmem_rvalid) begin
                    w_state_next = IDLE;
                    w_retire     = 1'b1;
                    w_ret_wen    = r_ld_wen;
                    w_ret_rd     = r_ld_rd;
                    w_ret_data   = w_align_data;
`ifdef WB_DIFFTEST_COMMIT_EN
                    w_ret_pc     = r_ld_pc;
                    w_ret_inst   = r_ld_inst;
`endif
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // FSM state register; reset drops any pending load.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Capture load context when a load is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ld_rd      <= 5'd0;
            r_ld_wen     <= 1'b0;
            r_ld_func    <= 3'd0;
            r_ld_addr_lo <= 3'd0;
`ifdef WB_DIFFTEST_COMMIT_EN
            r_ld_pc      <= 64'd0;
            r_ld_inst    <= 32'd0;
`endif
        end else if (w_accept && in_is_load) begin
            r_ld_rd      <= in_rd;
            r_ld_wen     <= in_rd_wen;
            r_ld_func    <= in_load_func;
            r_ld_addr_lo <= in_addr_lo;
`ifdef WB_DIFFTEST_COMMIT_EN
            r_ld_pc      <= in_pc;
            r_ld_inst    <= in_inst;
`endif
        end
    end

    // Register file write port: enable pulses per retirement (x0 masked),
    // address/data hold between retirements.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rf_we    <= 1'b0;
            r_rf_waddr <= 5'd0;
            r_rf_wdata <= '0;
        end else begin
            r_rf_we <= w_retire & w_ret_wen & (w_ret_rd != 5'd0);
            if (w_retire) begin
                r_rf_waddr <= w_ret_rd;
                r_rf_wdata <= w_ret_data;
            end
        end
    end

    assign rf_we    = r_rf_we;
    assign rf_waddr = r_rf_waddr;
    assign rf_wdata = r_rf_wdata;

`ifdef WB_DIFFTEST_COMMIT_EN
    // Commit trace: one pulse per retirement, including x0/no-write ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_commit_valid <= 1'b0;
            r_commit_pc    <= 64'd0;
            r_commit_inst  <= 32'd0;
            r_commit_cnt   <= 64'd0;
        end else begin
            r_commit_valid <= w_retire;
            if (w_retire) begin
                r_commit_pc   <= w_ret_pc;
                r_commit_inst <= w_ret_inst;
                r_commit_cnt  <= r_commit_cnt + 64'd1;
            end
        end
    end

    assign commit_valid = r_commit_valid;
    assign commit_pc    = r_commit_pc;
    assign commit_inst  = r_commit_inst;
    assign commit_cnt   = r_commit_cnt;
`endif

endmodule
